efi_stream_sorter: RTL and testbench

Extended-function-unit (EFI) accelerator for the fCore processor: receives a burst of operands on an AXI-Stream argument channel, sorts the values in ascending IEEE-754 single-precision order, and returns them on an AXI-Stream result channel. The core then writes each result back to its register file. Each result carries the destination of the argument slot it occupies, so values are sorted in place across the register addresses the core supplied.

---
 rtl/efi_sorter_pkg.sv | 15 +
 rtl/sort_compare_swap.sv | 19 +
 rtl/efi_stream_sorter.sv | 135 +++++++++++++
 tb/tb_efi_stream_sorter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/efi_sorter_pkg.sv
// efi_sorter_pkg: shared state, slot type and float ordering key for the EFI stream sorter
package efi_sorter_pkg;
  localparam int FLOAT_WIDTH = 32;
  localparam int SLOT_DEST_WIDTH = 8;
  localparam int SLOT_USER_WIDTH = 1;
  typedef enum logic [1:0] {RECEIVE, SORT, OUTPUT} state_t;
  typedef struct packed {
    logic [SLOT_DEST_WIDTH-1:0] dest;
    logic [SLOT_USER_WIDTH-1:0] user;
  } slot_t;
  // Unsigned key whose order matches float order: negatives invert every bit, positives flip only the sign
  function automatic logic [FLOAT_WIDTH-1:0] float_sort_key(input logic [FLOAT_WIDTH-1:0] x);
    return x ^ {1'b1, {(FLOAT_WIDTH-1){x[FLOAT_WIDTH-1]}}};
  endfunction
endpackage

// File: rtl/sort_compare_swap.sv
// sort_compare_swap: orders two floats by sort key and flags when the pair was out of order
//   a, b    : neighbouring values (positions j, j+1)
//   lo, hi  : the pair in ascending order
//   swapped : a belongs after b
module sort_compare_swap
  import efi_sorter_pkg::*;
(
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] lo,
  output logic [FLOAT_WIDTH-1:0] hi,
  output logic                   swapped
);
  always_comb begin
    swapped = float_sort_key(a) > float_sort_key(b);
    lo = swapped ? b : a;
    hi = swapped ? a : b;
  end
endmodule

// File: rtl/efi_stream_sorter.sv
// efi_stream_sorter: buffers an operand burst, bubble-sorts it as floats, returns it over the original dests
//   clock, reset   : single clock, synchronous active-high reset
//   efi_arguments_*: AXI-Stream slave carrying the operand burst (tlast marks the final operand)
//   efi_results_*  : AXI-Stream master carrying the sorted burst, dest/user taken from the slot each beat fills
module efi_stream_sorter
  import efi_sorter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_SORT_LENGTH = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] efi_arguments_tdata,
  input  logic [DEST_WIDTH-1:0] efi_arguments_tdest,
  input  logic [USER_WIDTH-1:0] efi_arguments_tuser,
  input  logic                  efi_arguments_tvalid,
  input  logic                  efi_arguments_tlast,
  output logic                  efi_arguments_tready,
  output logic [DATA_WIDTH-1:0] efi_results_tdata,
  output logic [DEST_WIDTH-1:0] efi_results_tdest,
  output logic [USER_WIDTH-1:0] efi_results_tuser,
  output logic                  efi_results_tvalid,
  output logic                  efi_results_tlast,
  input  logic                  efi_results_tready
);
  localparam int CW = $clog2(MAX_SORT_LENGTH + 1);
  localparam int IW = $clog2(MAX_SORT_LENGTH);
  state_t state;
  logic [DATA_WIDTH-1:0] value [MAX_SORT_LENGTH];
  slot_t slot [MAX_SORT_LENGTH];
  logic [CW-1:0] count, count_next;
  logic [IW-1:0] j, jn, k, kn;
  logic pass_swapped, sw;
  logic [DATA_WIDTH-1:0] lo, hi;
  always_comb begin
    count_next = (count == CW'(MAX_SORT_LENGTH)) ? count : count + CW'(1);
    jn = j + IW'(1);
    kn = k + IW'(1);
  end
  sort_compare_swap u_cmp (
    .a      (value[j]),
    .b      (value[jn]),
    .lo     (lo),
    .hi     (hi),
    .swapped(sw)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RECEIVE;
      count <= '0;
      j <= '0;
      k <= '0;
      pass_swapped <= 1'b0;
      efi_arguments_tready <= 1'b0;
      efi_results_tvalid <= 1'b0;
      efi_results_tdata <= '0;
      efi_results_tdest <= '0;
      efi_results_tuser <= '0;
      efi_results_tlast <= 1'b0;
    end else begin
      case (state)
        RECEIVE: begin
          efi_arguments_tready <= 1'b1;
          if (efi_arguments_tready && efi_arguments_tvalid) begin
            if (count < CW'(MAX_SORT_LENGTH)) begin
              value[count[IW-1:0]] <= efi_arguments_tdata;
              slot[count[IW-1:0]] <= '{dest: efi_arguments_tdest, user: efi_arguments_tuser};
            end
            count <= count_next;
            if (efi_arguments_tlast) begin
              efi_arguments_tready <= 1'b0;
              j <= '0;
              k <= '0;
              pass_swapped <= 1'b0;
              state <= (count == '0) ? OUTPUT : SORT;
              // A lone operand skips sorting; present it straight from the bus since value[0] is only now being written
              if (count == '0) begin
                efi_results_tvalid <= 1'b1;
                efi_results_tdata <= efi_arguments_tdata;
                efi_results_tdest <= efi_arguments_tdest;
                efi_results_tuser <= efi_arguments_tuser;
                efi_results_tlast <= 1'b1;
              end
            end
          end
        end
        SORT: begin
          if (sw) begin
            value[j] <= lo;
            value[jn] <= hi;
          end
          if (CW'(j) == count - CW'(2)) begin
            j <= '0;
            pass_swapped <= 1'b0;
            // A clean pass means the buffer is ordered, so value[0] is already final
            if (!(pass_swapped || sw)) begin
              state <= OUTPUT;
              efi_results_tvalid <= 1'b1;
              efi_results_tdata <= value[0];
              efi_results_tdest <= slot[0].dest;
              efi_results_tuser <= slot[0].user;
              efi_results_tlast <= 1'b0;
            end
          end else begin
            j <= jn;
            pass_swapped <= pass_swapped | sw;
          end
        end
        OUTPUT: begin
          if (efi_results_tvalid && efi_results_tready) begin
            if (efi_results_tlast) begin
              state <= RECEIVE;
              count <= '0;
              efi_arguments_tready <= 1'b1;
              efi_results_tvalid <= 1'b0;
              efi_results_tdata <= '0;
              efi_results_tdest <= '0;
              efi_results_tuser <= '0;
              efi_results_tlast <= 1'b0;
            end else begin
              k <= kn;
              efi_results_tdata <= value[kn];
              efi_results_tdest <= slot[kn].dest;
              efi_results_tuser <= slot[kn].user;
              efi_results_tlast <= (CW'(kn) == count - CW'(1));
            end
          end
        end
        default: state <= RECEIVE;
      endcase
    end
  end
endmodule

// File: tb/tb_efi_stream_sorter.sv
// tb_efi_stream_sorter: randomized and directed bursts checked against a sorted-array reference model
module tb_efi_stream_sorter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] a_data = '0;
  logic [7:0] a_dest = '0;
  logic a_user = 1'b0;
  logic a_valid = 1'b0;
  logic a_last = 1'b0;
  logic a_ready;
  logic [31:0] r_data;
  logic [7:0] r_dest;
  logic r_user, r_valid, r_last;
  logic r_ready = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [31:0] q_data[$];
  logic [7:0] q_dest[$];
  logic q_user[$];

  efi_stream_sorter dut (
    .clock               (clock),
    .reset               (reset),
    .efi_arguments_tdata (a_data),
    .efi_arguments_tdest (a_dest),
    .efi_arguments_tuser (a_user),
    .efi_arguments_tvalid(a_valid),
    .efi_arguments_tlast (a_last),
    .efi_arguments_tready(a_ready),
    .efi_results_tdata   (r_data),
    .efi_results_tdest   (r_dest),
    .efi_results_tuser   (r_user),
    .efi_results_tvalid  (r_valid),
    .efi_results_tlast   (r_last),
    .efi_results_tready  (r_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic give_up(input string tag, input int waited, input int limit);
    check(tag, 64'(waited), 64'(limit));
    finish_run();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] skey(input logic [31:0] x);
    return x[31] ? ~x : x ^ 32'h80000000;
  endfunction

  function automatic logic [31:0] rand_float();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'h00000000;
      2: return 32'h7FC00000;
      3: return 32'hFF800001;
      default: return $urandom();
    endcase
  endfunction

  task automatic clear();
    q_data.delete();
    q_dest.delete();
    q_user.delete();
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] dst, input logic u);
    q_data.push_back(d);
    q_dest.push_back(dst);
    q_user.push_back(u);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    a_valid = 1'b0;
    r_ready = 1'b0;
    repeat (n) begin
      tick();
      check("rst_valid", r_valid, 0);
      check("rst_data", r_data, 0);
      check("rst_dest", r_dest, 0);
      check("rst_user", r_user, 0);
      check("rst_last", r_last, 0);
      check("rst_arg_ready", a_ready, 0);
    end
    reset = 1'b0;
    tick();
    check("arg_ready_after_rst", a_ready, 1);
  endtask

  task automatic send(input bit gaps, output int t0);
    for (int i = 0; i < q_data.size(); i++) begin
      int w;
      w = 0;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        a_valid = 1'b0;
        tick();
      end
      a_data = q_data[i];
      a_dest = q_dest[i];
      a_user = q_user[i];
      a_last = (i == q_data.size() - 1);
      a_valid = 1'b1;
      while (!a_ready) begin
        tick();
        w++;
        if (w > 100) give_up("arg_ready_wait", w, 100);
      end
      tick();
    end
    a_valid = 1'b0;
    a_last = 1'b0;
    t0 = cyc;
  endtask

  // mode 0: sink always ready, 1: random ready, 2: stall 5 cycles while beat 1 is presented
  task automatic run(input int mode, input bit gaps);
    logic [31:0] ev [256];
    int n, m, p_max, t0, idx, stall, guard, lim;
    bit first, hs, rdy_high;
    n = q_data.size();
    m = n > 256 ? 256 : n;
    p_max = 0;
    idx = 0;
    stall = 0;
    guard = 0;
    first = 1'b1;
    rdy_high = 1'b0;
    for (int i = 0; i < m; i++) ev[i] = q_data[i];
    for (int i = 1; i < m; i++) begin
      logic [31:0] x;
      int p;
      x = ev[i];
      p = i - 1;
      while (p >= 0 && skey(ev[p]) > skey(x)) begin
        ev[p+1] = ev[p];
        p--;
      end
      ev[p+1] = x;
    end
    // Bubble passes that swap = most larger elements ahead of any one element; one more clean pass ends the sort
    for (int i = 0; i < m; i++) begin
      int c;
      c = 0;
      for (int p = 0; p < i; p++) if (skey(q_data[p]) > skey(q_data[i])) c++;
      if (c > p_max) p_max = c;
    end
    lim = m * m + 20 * m + 100;
    send(gaps, t0);
    while (idx < m) begin
      if (r_valid) begin
        if (first) begin
          check("first_valid_latency", 64'(cyc - t0), 64'((p_max + 1) * (m - 1)));
          first = 1'b0;
        end
        check("res_data", r_data, ev[idx]);
        check("res_dest", r_dest, q_dest[idx]);
        check("res_user", r_user, q_user[idx]);
        check("res_last", r_last, idx == m - 1);
      end
      if (a_ready) rdy_high = 1'b1;
      r_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : !(idx == 1 && stall < 5);
      if (mode == 2 && idx == 1 && r_valid && !r_ready) stall++;
      hs = r_valid && r_ready;
      tick();
      guard++;
      if (guard > lim) give_up("result_wait", guard, lim);
      if (hs) idx++;
    end
    r_ready = 1'b0;
    check("arg_ready_low_during_op", rdy_high, 0);
    check("valid_after_last", r_valid, 0);
    check("arg_ready_after_last", a_ready, 1);
  endtask

  initial begin
    int t0, w;
    do_reset(3);
    clear();
    push(32'h40400000, 8'd1, 1'b0);
    push(32'hBF800000, 8'd2, 1'b0);
    push(32'h3F000000, 8'd3, 1'b0);
    run(0, 1'b0);
    clear();
    push(32'h3F800000, 8'd4, 1'b1);
    push(32'h40000000, 8'd5, 1'b0);
    push(32'h40800000, 8'd6, 1'b1);
    run(0, 1'b0);
    clear();
    push(32'h40000000, 8'd7, 1'b1);
    run(0, 1'b0);
    clear();
    for (int i = 0; i < 8; i++) push(rand_float(), 8'($urandom()), 1'($urandom()));
    run(2, 1'b0);
    for (int b = 0; b < 6; b++) begin
      int n;
      clear();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) push(rand_float(), 8'($urandom()), 1'($urandom()));
      run(1, 1'b1);
    end
    clear();
    for (int i = 0; i < 260; i++) push(32'h40000000 + 32'(260 - i) * 32'h1000, 8'(i), 1'(i));
    run(0, 1'b0);
    clear();
    for (int i = 0; i < 12; i++) push(rand_float(), 8'($urandom()), 1'($urandom()));
    send(1'b0, t0);
    repeat (4) tick();
    do_reset(3);
    clear();
    push(32'h80000000, 8'h10, 1'b1);
    push(32'h00000000, 8'h11, 1'b0);
    run(0, 1'b0);
    clear();
    for (int i = 0; i < 4; i++) push(32'hC0000000 + 32'(i), 8'hA0 + 8'(i), 1'b1);
    send(1'b0, t0);
    w = 0;
    while (!r_valid) begin
      tick();
      w++;
      if (w > 100) give_up("valid_wait", w, 100);
    end
    do_reset(2);
    clear();
    push(32'h41000000, 8'h21, 1'b0);
    push(32'hC1000000, 8'h22, 1'b1);
    push(32'h00000001, 8'h23, 1'b0);
    run(1, 1'b1);
    finish_run();
  end
endmodule
